// File: rtl/pc_sequencer.sv
// Program counter sequencer: chooses PC+4 or a PC-relative branch/jump target,
// holds the PC across memory busywait stalls and counts stalled cycles.
module pc_sequencer #(
  parameter int                  PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int                  CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 BUSYWAIT,
  input  logic                 BEQ_signal,
  input  logic                 ZERO,
  input  logic                 J_signal,
  input  logic [7:0]           IMMEDIATE,
  output logic [PC_WIDTH-1:0]  PC,
  output logic                 PC_VALID,
  output logic                 REDIRECT,
  output logic [CNT_WIDTH-1:0] STALL_COUNT
);

  typedef enum logic [1:0] {BOOT, RUN, STALL} state_t;

  state_t               state, state_nxt;
  logic [PC_WIDTH-1:0]  pc_nxt, seq, tgt, offset;
  logic [PC_WIDTH-1:0]  pend_tgt, pend_tgt_nxt;
  logic                 pend_take, pend_take_nxt;
  logic                 take, valid_nxt, redir_nxt, cnt_inc;
  logic [CNT_WIDTH-1:0] cnt_nxt;

  always_comb begin
    seq    = PC + PC_WIDTH'(4);
    offset = {{(PC_WIDTH-10){IMMEDIATE[7]}}, IMMEDIATE, 2'b00};
    tgt    = seq + offset;
    take   = J_signal | (BEQ_signal & ZERO);

    state_nxt     = state;
    pc_nxt        = PC;
    valid_nxt     = PC_VALID;
    redir_nxt     = 1'b0;
    pend_take_nxt = pend_take;
    pend_tgt_nxt  = pend_tgt;
    cnt_inc       = 1'b0;

    case (state)
      BOOT: begin
        state_nxt = RUN;
        valid_nxt = 1'b1;
      end
      RUN: begin
        if (BUSYWAIT) begin
          // Decision made in the first stalled cycle is kept until release.
          pend_take_nxt = take;
          pend_tgt_nxt  = tgt;
          state_nxt     = STALL;
          cnt_inc       = 1'b1;
        end else begin
          pc_nxt    = take ? tgt : seq;
          redir_nxt = take;
        end
      end
      STALL: begin
        if (BUSYWAIT) begin
          cnt_inc = 1'b1;
        end else begin
          pc_nxt    = pend_take ? pend_tgt : seq;
          redir_nxt = pend_take;
          state_nxt = RUN;
        end
      end
      default: state_nxt = BOOT;
    endcase

    cnt_nxt = (cnt_inc && (STALL_COUNT != '1)) ? STALL_COUNT + CNT_WIDTH'(1) : STALL_COUNT;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= BOOT;
      PC          <= RESET_PC;
      PC_VALID    <= 1'b0;
      REDIRECT    <= 1'b0;
      STALL_COUNT <= '0;
      pend_take   <= 1'b0;
      pend_tgt    <= '0;
    end else begin
      state       <= state_nxt;
      PC          <= pc_nxt;
      PC_VALID    <= valid_nxt;
      REDIRECT    <= redir_nxt;
      STALL_COUNT <= cnt_nxt;
      pend_take   <= pend_take_nxt;
      pend_tgt    <= pend_tgt_nxt;
    end
  end

endmodule
